// File: rtl/image_pkg.sv
// image_pkg: shared geometry defaults, pixel/row types and window FSM states.
package image_pkg;

  localparam int unsigned WIDTH_DEF  = 320;
  localparam int unsigned HEIGHT_DEF = 240;
  localparam int unsigned PIX_W_DEF  = 8;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef pixel_t [0:WIDTH_DEF-1] row_t;

  typedef enum logic [1:0] {
    COLLECT,
    PRESENT,
    FLUSH
  } state_t;

endpackage

// File: rtl/line_window_feeder_if.sv
// line_window_feeder_if: pixel-stream input and three-row window output bundle.
interface line_window_feeder_if
  import image_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF
);

  logic [PIX_W-1:0]          pix_in;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [PIX_W-1:0]          row1 [0:WIDTH-1];
  logic [PIX_W-1:0]          row2 [0:WIDTH-1];
  logic [PIX_W-1:0]          row3 [0:WIDTH-1];
  logic                      row_valid;
  logic                      row_ready;
  logic [$clog2(HEIGHT)-1:0] row_y;
  logic                      frame_done;

  modport master (
    output pix_in, pix_valid, row_ready,
    input  pix_ready, row1, row2, row3, row_valid, row_y, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, row_ready,
    output pix_ready, row1, row2, row3, row_valid, row_y, frame_done
  );

endinterface

// File: rtl/line_window_feeder_ctrl.sv
// line_window_ctrl: window FSM plus column / received-row / centre-row counters.
module line_window_ctrl
  import image_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_pix_valid,
  input  logic                      i_row_ready,
  output logic                      o_pix_ready,
  output logic                      o_row_valid,
  output logic                      o_frame_done,
  output logic [$clog2(HEIGHT)-1:0] o_row_y,
  output logic                      o_wr_en,
  output logic [$clog2(WIDTH)-1:0]  o_wr_col,
  output logic                      o_shift,
  output logic                      o_clear,
  output logic                      o_flush
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT + 1);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RIN_LAST = RW'(HEIGHT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_rin;
  logic [YW-1:0] r_row_y;
  logic          r_frame_done;

  logic w_can_take;
  logic w_has_win;
  logic w_pix_acc;
  logic w_row_acc;
  logic w_row_end;

  // The frame_done cycle holds off input so the next frame starts one cycle later.
  assign w_can_take = (r_state == COLLECT) && !r_frame_done;
  assign w_has_win  = (r_state == PRESENT) || (r_state == FLUSH);
  assign w_pix_acc  = i_pix_valid && w_can_take;
  assign w_row_acc  = i_row_ready && w_has_win;
  assign w_row_end  = w_pix_acc && (r_col == COL_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_nxt;
  end

  // Next state: first row only primes mid, later rows each yield a window.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      COLLECT: if (w_row_end && (r_rin != '0)) w_state_nxt = PRESENT;
      PRESENT: if (w_row_acc) w_state_nxt = (r_rin == RIN_LAST) ? FLUSH : COLLECT;
      FLUSH:   if (w_row_acc) w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Handshake flags and row-register enables decoded from the current state.
  always_comb begin
    o_pix_ready = 1'b0;
    o_row_valid = 1'b0;
    o_wr_en     = 1'b0;
    o_shift     = 1'b0;
    o_clear     = 1'b0;
    o_flush     = 1'b0;
    unique case (r_state)
      COLLECT: begin
        o_pix_ready = w_can_take;
        o_wr_en     = w_pix_acc;
        o_shift     = w_row_end && (r_rin == '0);
      end
      PRESENT: begin
        o_row_valid = 1'b1;
        o_shift     = w_row_acc;
      end
      FLUSH: begin
        o_row_valid = 1'b1;
        o_flush     = 1'b1;
        o_clear     = w_row_acc;
      end
      default: ;
    endcase
  end

  // Column, received-row and centre-row counters plus the frame_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_rin        <= '0;
      r_row_y      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == FLUSH) && w_row_acc;
      if (w_pix_acc) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_rin <= r_rin + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_row_acc) begin
        if (r_state == FLUSH) begin
          r_rin   <= '0;
          r_row_y <= '0;
        end else begin
          r_row_y <= r_row_y + 1'b1;
        end
      end
    end
  end

  assign o_frame_done = r_frame_done;
  assign o_row_y      = r_row_y;
  assign o_wr_col     = r_col;

endmodule

// File: rtl/line_window_feeder.sv
// line_window_feeder: buffers a raster pixel stream into three row registers and
// presents (above, centre, below) windows with zero-padded top/bottom borders.
module line_window_feeder
  import image_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned HEIGHT = HEIGHT_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  line_window_feeder_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  logic [PIX_W-1:0] r_top     [0:WIDTH-1];
  logic [PIX_W-1:0] r_mid     [0:WIDTH-1];
  logic [PIX_W-1:0] r_bot     [0:WIDTH-1];
  logic [PIX_W-1:0] w_bot_nxt [0:WIDTH-1];

  logic          w_wr_en;
  logic          w_shift;
  logic          w_clear;
  logic          w_flush;
  logic [CW-1:0] w_wr_col;
  logic [YW-1:0] w_row_y;
  logic          w_pix_ready;
  logic          w_row_valid;
  logic          w_frame_done;

  line_window_ctrl #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .i_pix_valid  (bus.pix_valid),
    .i_row_ready  (bus.row_ready),
    .o_pix_ready  (w_pix_ready),
    .o_row_valid  (w_row_valid),
    .o_frame_done (w_frame_done),
    .o_row_y      (w_row_y),
    .o_wr_en      (w_wr_en),
    .o_wr_col     (w_wr_col),
    .o_shift      (w_shift),
    .o_clear      (w_clear),
    .o_flush      (w_flush)
  );

  // Bottom row with this cycle's pixel merged in, so a shift on the last
  // pixel of the first row moves the complete row into mid.
  always_comb begin
    w_bot_nxt = r_bot;
    if (w_wr_en) w_bot_nxt[w_wr_col] = bus.pix_in;
  end

  // Row registers: pixel write into bot, upward shift, end-of-frame clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top <= '{default: '0};
      r_mid <= '{default: '0};
      r_bot <= '{default: '0};
    end else if (w_clear) begin
      r_top <= '{default: '0};
      r_mid <= '{default: '0};
      r_bot <= '{default: '0};
    end else begin
      if (w_wr_en) r_bot <= w_bot_nxt;
      if (w_shift) begin
        r_top <= r_mid;
        r_mid <= w_bot_nxt;
      end
    end
  end

  assign bus.pix_ready  = w_pix_ready;
  assign bus.row_valid  = w_row_valid;
  assign bus.frame_done = w_frame_done;
  assign bus.row_y      = w_row_y;
  assign bus.row1       = r_top;
  assign bus.row2       = r_mid;

  // Below-row reads as zero while the last window of the frame is shown.
  always_comb begin
    for (int unsigned x = 0; x < WIDTH; x++) begin
      bus.row3[x] = w_flush ? '0 : r_bot[x];
    end
  end

endmodule

// File: tb/tb_line_window_feeder.sv
// tb_line_window_feeder: directed tests on a 4x3 instance and a default 320x240 instance.
module tb_line_window_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  line_window_feeder_if #(.WIDTH(4), .HEIGHT(3), .PIX_W(8)) ifs ();
  line_window_feeder_if #(.WIDTH(320), .HEIGHT(240), .PIX_W(8)) ifb ();

  line_window_feeder #(.WIDTH(4), .HEIGHT(3), .PIX_W(8)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  line_window_feeder #(.WIDTH(320), .HEIGHT(240), .PIX_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Snapshot of the small instance taken mid-cycle.
  logic        s_pr, s_rv, s_fd;
  logic [1:0]  s_y;
  logic [31:0] s_r1, s_r2, s_r3;

  // Results of run_small.
  int          rs_win, rs_acc, rs_fd, rs_first, rs_overlap, rs_unstable, rs_fdbad;
  bit          rs_timeout;
  logic [31:0] w1 [0:7];
  logic [31:0] w2 [0:7];
  logic [31:0] w3 [0:7];
  logic [1:0]  wy [0:7];

  // Packed row k of a frame whose first pixel is b: pixel x = b + 4k + x.
  function automatic logic [31:0] rowv(input logic [7:0] b, input int k);
    logic [31:0] r;
    logic [7:0]  p;
    r = '0;
    for (int x = 0; x < 4; x++) begin
      p = b + 8'(4 * k + x);
      r = {r[23:0], p};
    end
    return r;
  endfunction

  // Expected row (which = 1 above, 2 centre, 3 below) of global window w.
  function automatic logic [31:0] exp_row(input logic [7:0] base, input int w, input int which);
    int          j;
    logic [7:0]  fb;
    logic [31:0] r;
    j  = w % 3;
    fb = base + 8'(12 * (w / 3));
    if (which == 1)      r = (j == 0) ? 32'h0 : rowv(fb, j - 1);
    else if (which == 2) r = rowv(fb, j);
    else                 r = (j == 2) ? 32'h0 : rowv(fb, j + 1);
    return r;
  endfunction

  task automatic step_s(input logic pv, input logic [7:0] pin, input logic rr);
    @(negedge clk);
    ifs.pix_valid = pv;
    ifs.pix_in    = pin;
    ifs.row_ready = rr;
    #1;
    s_pr = ifs.pix_ready;
    s_rv = ifs.row_valid;
    s_fd = ifs.frame_done;
    s_y  = ifs.row_y;
    s_r1 = '0;
    s_r2 = '0;
    s_r3 = '0;
    for (int x = 0; x < 4; x++) begin
      s_r1 = {s_r1[23:0], ifs.row1[x]};
      s_r2 = {s_r2[23:0], ifs.row2[x]};
      s_r3 = {s_r3[23:0], ifs.row3[x]};
    end
  endtask

  // Streams nfr frames into the small instance and records what it observes.
  task automatic run_small(input logic [7:0] base, input int nfr, input bit toggle, input int stall_n);
    int          acc, stc, last_take;
    logic        pv, rr;
    logic [31:0] h1, h2, h3;
    logic [1:0]  hy;
    rs_win = 0; rs_fd = 0; rs_first = -1; rs_overlap = 0; rs_unstable = 0; rs_fdbad = 0;
    for (int i = 0; i < 8; i++) begin
      w1[i] = '1; w2[i] = '1; w3[i] = '1; wy[i] = '1;
    end
    acc = 0; stc = 0; last_take = -10;
    h1 = '0; h2 = '0; h3 = '0; hy = '0;
    for (int cyc = 0; cyc < 600 && rs_fd < nfr; cyc++) begin
      pv = (acc < 12 * nfr) && (!toggle || (cyc % 2 == 0));
      rr = (stc >= stall_n);
      step_s(pv, base + 8'(acc), rr);
      if (s_pr && s_rv) rs_overlap++;
      if (s_fd) begin
        rs_fd++;
        if (cyc != last_take + 1 || s_pr) rs_fdbad++;
      end
      if (s_rv && rs_first < 0) rs_first = acc;
      if (pv && s_pr) acc++;
      if (!s_rv && stc > 0) rs_unstable++;
      if (s_rv) begin
        if (stc == 0) begin
          h1 = s_r1; h2 = s_r2; h3 = s_r3; hy = s_y;
        end else if ({s_r1, s_r2, s_r3, s_y} !== {h1, h2, h3, hy} || s_pr) begin
          rs_unstable++;
        end
        if (rr) begin
          if (rs_win < 8) begin
            w1[rs_win] = s_r1; w2[rs_win] = s_r2; w3[rs_win] = s_r3; wy[rs_win] = s_y;
          end
          rs_win++;
          stc = 0;
          last_take = cyc;
        end else begin
          stc++;
        end
      end
    end
    rs_acc = acc;
    rs_timeout = (rs_fd < nfr);
    ifs.pix_valid = 1'b0;
    ifs.row_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({ifs.row_valid, ifs.frame_done, ifs.row_y} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b done=%b y=%0d required 0/0/0", ifs.row_valid, ifs.frame_done, ifs.row_y);
    end
    n_tests++;
    if ({ifs.row1[0], ifs.row2[3], ifs.row3[3], ifb.row2[100]} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rows: got nonzero row data, required 0");
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({ifs.pix_ready, ifs.row_valid, ifb.pix_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_release: got pix_ready=%b row_valid=%b big_ready=%b required 1/0/1", ifs.pix_ready, ifs.row_valid, ifb.pix_ready);
    end
  endtask

  task automatic test_stream();
    run_small(8'h00, 1, 1'b0, 0);
    n_tests++;
    if (rs_timeout || rs_win !== 3 || rs_acc !== 12) begin
      n_fail++;
      $display("FAIL stream_counts: got timeout=%0d windows=%0d pixels=%0d required 0/3/12", rs_timeout, rs_win, rs_acc);
    end
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if ({w1[w], w2[w], w3[w], wy[w]} !== {exp_row(8'h00, w, 1), exp_row(8'h00, w, 2), exp_row(8'h00, w, 3), 2'(w)}) begin
        n_fail++;
        $display("FAIL stream_win%0d: got %h/%h/%h y=%0d required %h/%h/%h y=%0d", w, w1[w], w2[w], w3[w], wy[w],
                 exp_row(8'h00, w, 1), exp_row(8'h00, w, 2), exp_row(8'h00, w, 3), w);
      end
    end
    n_tests++;
    if (rs_fd !== 1 || rs_fdbad !== 0 || rs_overlap !== 0) begin
      n_fail++;
      $display("FAIL stream_done: got pulses=%0d bad_timing=%0d overlap=%0d required 1/0/0", rs_fd, rs_fdbad, rs_overlap);
    end
    n_tests++;
    if (rs_first !== 8) begin
      n_fail++;
      $display("FAIL stream_first_valid: got after %0d pixels required 8", rs_first);
    end
  endtask

  task automatic test_stall();
    run_small(8'h00, 1, 1'b0, 5);
    n_tests++;
    if (rs_timeout || rs_win !== 3 || rs_acc !== 12 || rs_unstable !== 0) begin
      n_fail++;
      $display("FAIL stall_hold: got timeout=%0d windows=%0d pixels=%0d unstable=%0d required 0/3/12/0", rs_timeout, rs_win, rs_acc, rs_unstable);
    end
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if ({w1[w], w2[w], w3[w], wy[w]} !== {exp_row(8'h00, w, 1), exp_row(8'h00, w, 2), exp_row(8'h00, w, 3), 2'(w)}) begin
        n_fail++;
        $display("FAIL stall_win%0d: got %h/%h/%h y=%0d required %h/%h/%h y=%0d", w, w1[w], w2[w], w3[w], wy[w],
                 exp_row(8'h00, w, 1), exp_row(8'h00, w, 2), exp_row(8'h00, w, 3), w);
      end
    end
    n_tests++;
    if (rs_fd !== 1 || rs_fdbad !== 0 || rs_overlap !== 0) begin
      n_fail++;
      $display("FAIL stall_done: got pulses=%0d bad_timing=%0d overlap=%0d required 1/0/0", rs_fd, rs_fdbad, rs_overlap);
    end
  endtask

  task automatic test_toggle();
    run_small(8'h00, 1, 1'b1, 0);
    n_tests++;
    if (rs_timeout || rs_win !== 3 || rs_acc !== 12 || rs_first !== 8) begin
      n_fail++;
      $display("FAIL toggle_counts: got timeout=%0d windows=%0d pixels=%0d first_valid_after=%0d required 0/3/12/8", rs_timeout, rs_win, rs_acc, rs_first);
    end
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if ({w1[w], w2[w], w3[w], wy[w]} !== {exp_row(8'h00, w, 1), exp_row(8'h00, w, 2), exp_row(8'h00, w, 3), 2'(w)}) begin
        n_fail++;
        $display("FAIL toggle_win%0d: got %h/%h/%h y=%0d required %h/%h/%h y=%0d", w, w1[w], w2[w], w3[w], wy[w],
                 exp_row(8'h00, w, 1), exp_row(8'h00, w, 2), exp_row(8'h00, w, 3), w);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step_s(1'b1, 8'h50 + 8'(i), 1'b1);
    @(negedge clk);
    ifs.pix_valid = 1'b0;
    ifs.row_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ifs.row_valid, ifs.frame_done, ifs.row2[0], ifs.row2[3], ifs.row3[0], ifs.row3[1], ifs.row1[0]} !== 42'h0) begin
      n_fail++;
      $display("FAIL midreset_clear: got valid=%b row2[0]=%h row3[1]=%h required all zero", ifs.row_valid, ifs.row2[0], ifs.row3[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (ifs.pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b required 1", ifs.pix_ready);
    end
    run_small(8'h10, 1, 1'b0, 0);
    n_tests++;
    if ({w1[0], w2[0], w3[0], wy[0]} !== {32'h0, 32'h10111213, 32'h14151617, 2'd0}) begin
      n_fail++;
      $display("FAIL midreset_win0: got %h/%h/%h y=%0d required 00000000/10111213/14151617 y=0", w1[0], w2[0], w3[0], wy[0]);
    end
    n_tests++;
    if (rs_timeout || rs_win !== 3 || w3[2] !== 32'h0 || w2[2] !== 32'h18191a1b) begin
      n_fail++;
      $display("FAIL midreset_frame: got timeout=%0d windows=%0d last=%h/%h required 0/3/18191a1b/00000000", rs_timeout, rs_win, w2[2], w3[2]);
    end
  endtask

  task automatic test_back_to_back();
    run_small(8'h20, 2, 1'b0, 0);
    n_tests++;
    if (rs_timeout || rs_win !== 6 || rs_fd !== 2 || rs_acc !== 24 || rs_fdbad !== 0) begin
      n_fail++;
      $display("FAIL b2b_counts: got timeout=%0d windows=%0d pulses=%0d pixels=%0d bad_timing=%0d required 0/6/2/24/0",
               rs_timeout, rs_win, rs_fd, rs_acc, rs_fdbad);
    end
    n_tests++;
    if ({w1[3], w2[3]} !== {32'h0, 32'h2c2d2e2f}) begin
      n_fail++;
      $display("FAIL b2b_second_top: got %h/%h required 00000000/2c2d2e2f", w1[3], w2[3]);
    end
    for (int w = 0; w < 6; w++) begin
      n_tests++;
      if ({w1[w], w2[w], w3[w], wy[w]} !== {exp_row(8'h20, w, 1), exp_row(8'h20, w, 2), exp_row(8'h20, w, 3), 2'(w % 3)}) begin
        n_fail++;
        $display("FAIL b2b_win%0d: got %h/%h/%h y=%0d required %h/%h/%h y=%0d", w, w1[w], w2[w], w3[w], wy[w],
                 exp_row(8'h20, w, 1), exp_row(8'h20, w, 2), exp_row(8'h20, w, 3), w % 3);
      end
    end
  endtask

  task automatic test_default_size();
    int         acc, nw, nfd, bad, zb;
    logic [7:0] e1, e2, e3;
    acc = 0; nw = 0; nfd = 0;
    for (int cyc = 0; cyc < 80000 && nfd == 0; cyc++) begin
      @(negedge clk);
      ifb.pix_valid = (acc < 76800);
      ifb.pix_in    = 8'(acc);
      ifb.row_ready = 1'b1;
      #1;
      if (ifb.frame_done) nfd++;
      if (ifb.row_valid) begin
        bad = 0;
        for (int x = 0; x < 320; x++) begin
          e1 = (nw == 0)   ? 8'h0 : 8'((nw - 1) * 320 + x);
          e2 = 8'(nw * 320 + x);
          e3 = (nw == 239) ? 8'h0 : 8'((nw + 1) * 320 + x);
          if (ifb.row1[x] !== e1 || ifb.row2[x] !== e2 || ifb.row3[x] !== e3) bad++;
        end
        n_tests++;
        if (bad != 0 || ifb.row_y !== 8'(nw)) begin
          n_fail++;
          $display("FAIL big_win%0d: got %0d bad pixels row_y=%0d required 0 bad row_y=%0d", nw, bad, ifb.row_y, nw);
        end
        if (nw == 239) begin
          zb = 0;
          for (int x = 0; x < 320; x++) if (ifb.row3[x] !== 8'h0) zb++;
          n_tests++;
          if (zb != 0) begin
            n_fail++;
            $display("FAIL big_last_row3: got %0d nonzero pixels required 0", zb);
          end
        end
        nw++;
      end
      if (ifb.pix_valid && ifb.pix_ready) acc++;
    end
    ifb.pix_valid = 1'b0;
    ifb.row_ready = 1'b0;
    n_tests++;
    if (nw !== 240 || nfd !== 1 || acc !== 76800) begin
      n_fail++;
      $display("FAIL big_counts: got windows=%0d pulses=%0d pixels=%0d required 240/1/76800", nw, nfd, acc);
    end
  endtask

  initial begin
    ifs.pix_valid = 1'b0; ifs.pix_in = '0; ifs.row_ready = 1'b0;
    ifb.pix_valid = 1'b0; ifb.pix_in = '0; ifb.row_ready = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_toggle();
    test_reset_mid();
    test_back_to_back();
    test_default_size();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_feeder.md
Name: line_window_feeder

Overview:
- Streaming front end for the row-window edge-detection core: accepts a raster pixel stream one pixel per cycle.
- Buffers lines and presents three complete, vertically adjacent rows (above, centre, below) in parallel, one window per centre row.
- Performs in hardware the row shifting and file reading that the simulation bench does for the core today.
- Top and bottom image borders are zero-padded, so exactly HEIGHT windows are produced per frame.

Parameters:
- WIDTH, 320, pixels per row (≥2)
- HEIGHT, 240, rows per frame (≥2)
- PIX_W, 8, bits per pixel

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pix_in  in  PIX_W  input pixel, raster order
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  feeder can accept a pixel this cycle
- row1  out  PIX_W x [0:WIDTH-1]  row above centre (unpacked array)
- row2  out  PIX_W x [0:WIDTH-1]  centre row
- row3  out  PIX_W x [0:WIDTH-1]  row below centre
- row_valid  out  1  row1/row2/row3 hold a valid window
- row_ready  in  1  consumer takes the window
- row_y  out  $clog2(HEIGHT)  index of the centre row
- frame_done  out  1  one-cycle pulse after the last window is taken

Behaviour:
- Reset (async, any state, mid-row or mid-window): top/mid/bot row registers cleared to 0; col=0, rin=0, row_y=0; state=COLLECT; row_valid=0, frame_done=0. pix_ready is 1 in the first cycle after reset release.
- Storage: three WIDTH x PIX_W registers top/mid/bot. Outputs row1=top, row2=mid, row3=bot, except in FLUSH, where row3 is forced to 0.
- Counters: col in 0..WIDTH-1; rin in 0..HEIGHT (rows fully received this frame).
- COLLECT:
  - pix_ready=1, row_valid=0.
  - On pix_valid&&pix_ready: bot[col]<=pix_in, col++.
  - On accepting col==WIDTH-1: col<=0, rin<=rin+1.
  - If rin was 0 (first row just completed): top<=mid (0), mid<=bot; stay in COLLECT.
  - Otherwise go to PRESENT.
- PRESENT:
  - pix_ready=0, row_valid=1.
  - Window = (top, mid, bot), centre = row rin-2 (frame row index); row_y holds that value.
  - Outputs are stable until row_ready is seen.
  - On row_valid&&row_ready: top<=mid, mid<=bot, row_y++.
  - If rin==HEIGHT, go to FLUSH; else go to COLLECT. bot keeps stale data and is fully overwritten before its next use.
- FLUSH:
  - row_valid=1, pix_ready=0, row3=0.
  - Window = (top, mid, 0), row_y=HEIGHT-1.
  - On row_ready: frame_done=1 for one cycle; top/mid/bot cleared, rin=0, row_y=0; go to COLLECT.
- Latency:
  - row_valid rises the cycle after the last pixel of row k+1 is accepted (window centred on row k).
  - A window is consumed in the cycle row_valid&&row_ready is sampled high.
  - The next pixel can be accepted the cycle after that.
- Handshakes:
  - pix_ready and row_valid are never 1 together.
  - row_ready while row_valid=0 is ignored.
  - pix_valid while pix_ready=0 is ignored; the pixel is not consumed and the source must hold it.
- Frame boundaries:
  - The first window of a frame has row1=0.
  - The last window has row3=0.
  - Exactly HEIGHT windows and one frame_done pulse per frame.
  - The next frame's first pixel is accepted starting the cycle after the frame_done cycle.
- No pixel drop or duplication under any pix_valid/row_ready pattern, including row_ready held high and pix_valid toggling every cycle.

Decomposition:
- Shared package image_pkg: WIDTH/HEIGHT/PIX_W defaults, the pixel_t typedef, the row_t typedef (pixel_t [0:WIDTH-1]), and the state enum {COLLECT, PRESENT, FLUSH}.
- One natural sub-module: line_window_ctrl, holding the FSM and the col/rin/row_y counters and issuing shift/write enables. The row registers stay in the top module.

Test Plan (WIDTH=4, HEIGHT=3 unless stated):
1. Stream pixels 0x00..0x0B with pix_valid held high and row_ready held high.
   - Windows: (0,R0,R1) row_y=0; (R0,R1,R2) row_y=1; (R1,R2,0) row_y=2.
   - R0=00 01 02 03, R1=04..07, R2=08..0B.
   - frame_done pulses once, 1 cycle after the third window is taken.
2. Same stream with row_ready held low for 5 cycles at each window.
   - row_valid held high and row1..3 stable throughout.
   - pix_ready=0 throughout the stall.
   - No pixel lost; window contents as in scenario 1.
3. pix_valid toggling 1/0 every cycle.
   - 12 accepted pixels; identical windows.
   - The first row_valid occurs after the 8th accepted pixel.
4. Assert rst after 6 pixels, then stream a fresh 12-pixel frame 0x10..0x1B.
   - Outputs zero and row_valid=0 immediately on reset.
   - First window is (0, 10 11 12 13, 14 15 16 17), row_y=0.
5. Two back-to-back frames.
   - Second frame's first window has row1=0, not stale data.
   - Exactly 6 windows and 2 frame_done pulses in total.
6. Default parameters (320x240) with the 0..255 ramp pattern.
   - 240 windows produced.
   - Window y: row2[x]=(y*320+x) mod 256.
   - Window 239: row3 all zero.
